// File: rtl/cond_match_unit_if.sv
// Bundles the sample, rule-programming and status signals of cond_match_unit.
// The master drives samples/config; the slave (the unit) returns hit status.
interface cond_match_unit_if #(
  parameter int A_W       = 3,
  parameter int C_W       = 2,
  parameter int NUM_RULES = 2,
  parameter int CNT_W     = 8
);
  localparam int IDX_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;

  logic                 in_valid;
  logic [A_W-1:0]       a;
  logic                 b;
  logic [C_W-1:0]       c;
  logic                 cfg_we;
  logic [IDX_W-1:0]     cfg_idx;
  logic                 cfg_en;
  logic [A_W-1:0]       cfg_a;
  logic                 cfg_b;
  logic [C_W-1:0]       cfg_c;
  logic                 clr;
  logic                 y;
  logic [NUM_RULES-1:0] hit_vec;
  logic [IDX_W-1:0]     hit_id;
  logic [CNT_W-1:0]     hit_cnt;
  logic                 cnt_sat;

  modport master (
    output in_valid, a, b, c, cfg_we, cfg_idx, cfg_en, cfg_a, cfg_b, cfg_c, clr,
    input  y, hit_vec, hit_id, hit_cnt, cnt_sat
  );
  modport slave (
    input  in_valid, a, b, c, cfg_we, cfg_idx, cfg_en, cfg_a, cfg_b, cfg_c, clr,
    output y, hit_vec, hit_id, hit_cnt, cnt_sat
  );
endinterface

// File: rtl/cond_match_unit.sv
// Programmable tuple matcher: per-rule pattern + run counter, fixed-priority
// resolution to y/hit_id, and a saturating count of y rising edges.

module cmu_rule #(
  parameter int             A_W    = 3,
  parameter int             C_W    = 2,
  parameter int             HOLD   = 1,
  parameter logic           RST_EN = 1'b0,
  parameter logic [A_W-1:0] RST_A  = '0,
  parameter logic           RST_B  = 1'b0,
  parameter logic [C_W-1:0] RST_C  = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [A_W-1:0] a,
  input  logic           b,
  input  logic [C_W-1:0] c,
  input  logic           wr,
  input  logic           cfg_en,
  input  logic [A_W-1:0] cfg_a,
  input  logic           cfg_b,
  input  logic [C_W-1:0] cfg_c,
  output logic           hit_nxt,
  output logic           hit
);
  localparam int RUN_W = $clog2(HOLD + 1);

  logic           en, pb, m;
  logic [A_W-1:0] pa;
  logic [C_W-1:0] pc;
  logic [RUN_W-1:0] run, run_nxt;

  assign m = en & (a == pa) & (b == pb) & (c == pc);

  // A config write overrides whatever the concurrent sample would have done.
  always_comb begin
    run_nxt = run;
    hit_nxt = hit;
    if (wr) begin
      run_nxt = '0;
      hit_nxt = 1'b0;
    end else if (in_valid) begin
      if (m) begin
        if (run != RUN_W'(HOLD)) run_nxt = run + RUN_W'(1);
        hit_nxt = (run_nxt == RUN_W'(HOLD));
      end else begin
        run_nxt = '0;
        hit_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= RST_EN;
      pa  <= RST_A;
      pb  <= RST_B;
      pc  <= RST_C;
      run <= '0;
      hit <= 1'b0;
    end else begin
      run <= run_nxt;
      hit <= hit_nxt;
      if (wr) begin
        en <= cfg_en;
        pa <= cfg_a;
        pb <= cfg_b;
        pc <= cfg_c;
      end
    end
  end
endmodule

module cond_match_unit #(
  parameter int A_W       = 3,
  parameter int C_W       = 2,
  parameter int NUM_RULES = 2,
  parameter int HOLD      = 1,
  parameter int CNT_W     = 8
) (
  input logic               clk,
  input logic               rst_n,
  cond_match_unit_if.slave  bus
);
  localparam int IDX_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;

  logic [NUM_RULES-1:0] hit_vec, hit_nxt;
  logic [IDX_W-1:0]     hit_id;
  logic [CNT_W-1:0]     cnt, cnt_inc;
  logic                 sat, y, y_rise;

  generate
    for (genvar i = 0; i < NUM_RULES; i++) begin : g_rule
      cmu_rule #(
        .A_W   (A_W),
        .C_W   (C_W),
        .HOLD  (HOLD),
        .RST_EN((i < 2) ? 1'b1 : 1'b0),
        .RST_A ((i < 2) ? A_W'(2) : A_W'(0)),
        .RST_B ((i == 0) ? 1'b1 : 1'b0),
        .RST_C (C_W'(0))
      ) u_rule (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(bus.in_valid),
        .a       (bus.a),
        .b       (bus.b),
        .c       (bus.c),
        .wr      (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))),
        .cfg_en  (bus.cfg_en),
        .cfg_a   (bus.cfg_a),
        .cfg_b   (bus.cfg_b),
        .cfg_c   (bus.cfg_c),
        .hit_nxt (hit_nxt[i]),
        .hit     (hit_vec[i])
      );
    end
  endgenerate

  // Scan high to low so the lowest qualified index is the one left standing.
  always_comb begin
    hit_id = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--)
      if (hit_vec[i]) hit_id = IDX_W'(i);
  end

  assign y       = |hit_vec;
  assign y_rise  = (|hit_nxt) & ~y;
  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (bus.clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (y_rise && !(&cnt)) begin
      cnt <= cnt_inc;
      sat <= sat | (&cnt_inc);
    end
  end

  assign bus.y       = y;
  assign bus.hit_vec = hit_vec;
  assign bus.hit_id  = hit_id;
  assign bus.hit_cnt = cnt;
  assign bus.cnt_sat = sat;
endmodule

// File: tb/tb_cond_match_unit.sv
// Scoreboard bench: three units (HOLD=1, HOLD=3, CNT_W=2) driven by directed
// vectors; a monitor process checks queued expectations after each edge.
module tb_cond_match_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cond_match_unit_if #(.A_W(3), .C_W(2), .NUM_RULES(2), .CNT_W(8)) b0 ();
  cond_match_unit_if #(.A_W(3), .C_W(2), .NUM_RULES(2), .CNT_W(8)) b1 ();
  cond_match_unit_if #(.A_W(3), .C_W(2), .NUM_RULES(2), .CNT_W(2)) b2 ();

  cond_match_unit #(.A_W(3), .C_W(2), .NUM_RULES(2), .HOLD(1), .CNT_W(8))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  cond_match_unit #(.A_W(3), .C_W(2), .NUM_RULES(2), .HOLD(3), .CNT_W(8))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  cond_match_unit #(.A_W(3), .C_W(2), .NUM_RULES(2), .HOLD(1), .CNT_W(2))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // {y, hit_vec[1:0], hit_id, hit_cnt[7:0], cnt_sat}
  typedef struct {
    int          cyc;
    int          d;
    logic [12:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  function automatic logic [12:0] act(int d);
    case (d)
      0:       return {b0.y, b0.hit_vec, b0.hit_id, b0.hit_cnt, b0.cnt_sat};
      1:       return {b1.y, b1.hit_vec, b1.hit_id, b1.hit_cnt, b1.cnt_sat};
      default: return {b2.y, b2.hit_vec, b2.hit_id, 6'd0, b2.hit_cnt, b2.cnt_sat};
    endcase
  endfunction

  task automatic smp(int d, logic v, logic [2:0] a, logic b, logic [1:0] c);
    case (d)
      0: begin b0.in_valid = v; b0.a = a; b0.b = b; b0.c = c; b0.cfg_we = 1'b0; b0.clr = 1'b0; end
      1: begin b1.in_valid = v; b1.a = a; b1.b = b; b1.c = c; b1.cfg_we = 1'b0; b1.clr = 1'b0; end
      default: begin b2.in_valid = v; b2.a = a; b2.b = b; b2.c = c; b2.cfg_we = 1'b0; b2.clr = 1'b0; end
    endcase
  endtask

  task automatic cfg(int d, logic idx, logic en, logic [2:0] a, logic b, logic [1:0] c);
    case (d)
      0: begin b0.cfg_we = 1'b1; b0.cfg_idx = idx; b0.cfg_en = en; b0.cfg_a = a; b0.cfg_b = b; b0.cfg_c = c; end
      1: begin b1.cfg_we = 1'b1; b1.cfg_idx = idx; b1.cfg_en = en; b1.cfg_a = a; b1.cfg_b = b; b1.cfg_c = c; end
      default: begin b2.cfg_we = 1'b1; b2.cfg_idx = idx; b2.cfg_en = en; b2.cfg_a = a; b2.cfg_b = b; b2.cfg_c = c; end
    endcase
  endtask

  task automatic ex(int d, logic y, logic [1:0] hv, logic id, logic [7:0] cnt, logic sat);
    exp_t e;
    e.cyc = cyc + 1;
    e.d   = d;
    e.v   = {y, hv, id, cnt, sat};
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zchk(int d);
    logic [12:0] got;
    got = act(d);
    total++;
    if (got !== 13'd0) begin
      bad++;
      $display("FAIL reset_zero d%0d got=%b want=0", d, got);
    end
  endtask

  // Monitor: reset drops are checked without a clock; otherwise drain due entries.
  initial begin
    exp_t        e;
    logic [12:0] got;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        #2;
        for (int d = 0; d < 3; d++) zchk(d);
      end else begin
        cyc++;
        #2;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e   = sb.pop_front();
          got = act(e.d);
          total++;
          if (got !== e.v) begin
            bad++;
            $display("FAIL chk d%0d cyc%0d got y=%b hv=%b id=%b cnt=%0d sat=%b want y=%b hv=%b id=%b cnt=%0d sat=%b",
                     e.d, e.cyc, got[12], got[11:10], got[9], got[8:1], got[0],
                     e.v[12], e.v[11:10], e.v[9], e.v[8:1], e.v[0]);
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      smp(d, 0, 0, 0, 0);
      cfg(d, 0, 0, 0, 0, 0);
      smp(d, 0, 0, 0, 0);
    end
    #1 rst_n = 1'b0;
    #3;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // rule0 then rule1 defaults, HOLD=1
    smp(0, 1, 2, 1, 0); ex(0, 1, 2'b01, 0, 1, 0); tick();
    smp(0, 1, 2, 0, 0); ex(0, 1, 2'b10, 1, 1, 0); tick();
    // mismatch clears, gaps hold
    smp(0, 1, 3, 1, 0); ex(0, 0, 2'b00, 0, 1, 0); tick();
    smp(0, 1, 2, 1, 0); ex(0, 1, 2'b01, 0, 2, 0); tick();
    smp(0, 0, 3, 0, 0); ex(0, 1, 2'b01, 0, 2, 0); tick();
    smp(0, 0, 2, 0, 0); ex(0, 1, 2'b01, 0, 2, 0); tick();
    smp(0, 1, 3, 0, 0); ex(0, 0, 2'b00, 0, 2, 0); tick();

    // HOLD=3 with a gap, then a restart after a mismatch
    smp(1, 1, 2, 1, 0); ex(1, 0, 2'b00, 0, 0, 0); tick();
    smp(1, 0, 2, 1, 0); ex(1, 0, 2'b00, 0, 0, 0); tick();
    smp(1, 1, 2, 1, 0); ex(1, 0, 2'b00, 0, 0, 0); tick();
    smp(1, 1, 2, 1, 0); ex(1, 1, 2'b01, 0, 1, 0); tick();
    smp(1, 1, 2, 1, 0); ex(1, 1, 2'b01, 0, 1, 0); tick();
    smp(1, 1, 3, 1, 0); ex(1, 0, 2'b00, 0, 1, 0); tick();
    smp(1, 1, 2, 1, 0); ex(1, 0, 2'b00, 0, 1, 0); tick();
    smp(1, 1, 2, 1, 0); ex(1, 0, 2'b00, 0, 1, 0); tick();
    smp(1, 1, 3, 1, 0); ex(1, 0, 2'b00, 0, 1, 0); tick();
    smp(1, 1, 2, 1, 0); ex(1, 0, 2'b00, 0, 1, 0); tick();
    smp(1, 1, 2, 1, 0); ex(1, 0, 2'b00, 0, 1, 0); tick();
    smp(1, 1, 2, 1, 0); ex(1, 1, 2'b01, 0, 2, 0); tick();
    smp(1, 0, 0, 0, 0);

    // reprogram rule1, overlapping hits, config write racing a match
    smp(0, 0, 0, 0, 0); cfg(0, 1, 1, 2, 1, 0); ex(0, 0, 2'b00, 0, 2, 0); tick();
    smp(0, 1, 2, 1, 0); ex(0, 1, 2'b11, 0, 3, 0); tick();
    smp(0, 1, 2, 1, 0); cfg(0, 0, 0, 2, 1, 0); ex(0, 1, 2'b10, 1, 3, 0); tick();
    smp(0, 1, 2, 1, 0); ex(0, 1, 2'b10, 1, 3, 0); tick();
    smp(0, 0, 0, 0, 0);

    // CNT_W=2 saturation, then clr colliding with a rising edge
    for (int i = 0; i < 5; i++) begin
      smp(2, 1, 2, 1, 0); ex(2, 1, 2'b01, 0, 8'((i < 2) ? i + 1 : 3), (i >= 2)); tick();
      smp(2, 1, 3, 1, 0); ex(2, 0, 2'b00, 0, 8'((i < 2) ? i + 1 : 3), (i >= 2)); tick();
    end
    smp(2, 1, 2, 1, 0); b2.clr = 1'b1; ex(2, 1, 2'b01, 0, 0, 0); tick();
    smp(2, 1, 3, 1, 0); ex(2, 0, 2'b00, 0, 0, 0); tick();
    smp(2, 1, 2, 1, 0); ex(2, 1, 2'b01, 0, 1, 0); tick();
    smp(2, 0, 0, 0, 0);

    // async reset mid-run, then defaults are live again
    #3 rst_n = 1'b0;
    #3;
    @(negedge clk) rst_n = 1'b1;
    tick();
    smp(0, 1, 2, 1, 0); ex(0, 1, 2'b01, 0, 1, 0); tick();
    smp(0, 1, 2, 0, 0); ex(0, 1, 2'b10, 1, 1, 0); tick();
    smp(0, 0, 0, 0, 0);
    #5;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
